// File: rtl/rv32_mod_pc_ras.sv
// Fetch program counter with prioritised trap/redirect steering and a circular
// return-address stack that predicts the target of `ret`.
module rv32_mod_pc_ras #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h1000_0000),
    parameter int               RAS_DEPTH    = 4,
    parameter bit               ENABLE_C     = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         stall,
    input  logic                         is_compressed,
    output logic [XLEN-1:0]              pc_current,
    output logic [XLEN-1:0]              pc_next,
    input  logic                         trap_enable,
    input  logic [XLEN-1:0]              trap_vector,
    input  logic                         redirect_enable,
    input  logic [XLEN-1:0]              redirect_target,
    input  logic                         call,
    input  logic                         ret,
    output logic [XLEN-1:0]              ras_top,
    output logic                         ras_empty,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         misaligned_fault
);

    localparam int              PW      = $clog2(RAS_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fault_q, fault_d;

    logic [PW-1:0]   top_idx;
    logic            empty;
    logic            use_c;
    logic            target_bad;
    logic            pop_ok;

    // ptr_q is the next free slot; the newest entry sits just below it
    always_comb begin
        use_c      = ENABLE_C && is_compressed;
        pc_next    = pc_q + (use_c ? XLEN'(2) : XLEN'(4));
        top_idx    = ptr_q - PW'(1);
        empty      = (cnt_q == '0);
        ras_top    = empty ? '0 : ras_q[top_idx];
        target_bad = redirect_target[0] || (!ENABLE_C && redirect_target[1]);
        pop_ok     = ret && !empty;
    end

    always_comb begin
        pc_d    = pc_q;
        ras_d   = ras_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (!stall) begin
            fault_d = 1'b0;
            if (trap_enable) begin
                pc_d  = {trap_vector[XLEN-1:2], 2'b00};
                cnt_d = '0;
                ptr_d = '0;
            end else if (redirect_enable) begin
                if (target_bad) begin
                    fault_d = 1'b1;
                end else begin
                    pc_d = redirect_target;
                end
            end else begin
                pc_d = pop_ok ? ras_top : pc_next;
                // call+ret on a non-empty stack swaps the top in place
                if (call && pop_ok) begin
                    ras_d[top_idx] = pc_next;
                end else if (pop_ok) begin
                    ptr_d = top_idx;
                    cnt_d = cnt_q - CW'(1);
                end else if (call) begin
                    ras_d[ptr_q] = pc_next;
                    ptr_d        = ptr_q + PW'(1);
                    if (cnt_q != DEPTH_C) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            ptr_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            ras_q   <= ras_d;
        end
    end

    assign pc_current       = pc_q;
    assign ras_empty        = empty;
    assign ras_count        = cnt_q;
    assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_rv32_mod_pc_ras.sv
// Scoreboard bench: two instances (compressed on/off) share stimulus and are
// compared each cycle against a bottom-up array stack reference model.
module tb_rv32_mod_pc_ras;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [31:0] top;
        logic [2:0]  cnt;
        logic        empty;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic        is_compressed = 1'b0;
    logic        trap_enable = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        redirect_enable = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;

    logic [31:0] pc_c, pcn_c, top_c, pc_n, pcn_n, top_n;
    logic        empty_c, fault_c, empty_n, fault_n;
    logic [2:0]  cnt_c, cnt_n;

    logic [31:0] m_pc [2];
    logic [31:0] m_stk [2][4];
    int          m_n [2];
    bit          m_fault [2];

    exp_t sb_c[$];
    exp_t sb_n[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rv32_mod_pc_ras #(.ENABLE_C(1'b1)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .stall(stall), .is_compressed(is_compressed),
        .pc_current(pc_c), .pc_next(pcn_c), .trap_enable(trap_enable),
        .trap_vector(trap_vector), .redirect_enable(redirect_enable),
        .redirect_target(redirect_target), .call(call), .ret(ret),
        .ras_top(top_c), .ras_empty(empty_c), .ras_count(cnt_c),
        .misaligned_fault(fault_c)
    );

    rv32_mod_pc_ras #(.ENABLE_C(1'b0)) u_dut_nc (
        .clk(clk), .reset_n(reset_n), .stall(stall), .is_compressed(is_compressed),
        .pc_current(pc_n), .pc_next(pcn_n), .trap_enable(trap_enable),
        .trap_vector(trap_vector), .redirect_enable(redirect_enable),
        .redirect_target(redirect_target), .call(call), .ret(ret),
        .ras_top(top_n), .ras_empty(empty_n), .ras_count(cnt_n),
        .misaligned_fault(fault_n)
    );

    // Model index 0 has compressed support, index 1 does not
    function automatic logic [31:0] modelInc(int k);
        return (k == 0 && is_compressed) ? 32'd2 : 32'd4;
    endfunction

    function automatic exp_t makeExp(int k);
        exp_t e;
        e.pc    = m_pc[k];
        e.pcn   = m_pc[k] + modelInc(k);
        e.top   = (m_n[k] > 0) ? m_stk[k][m_n[k]-1] : 32'd0;
        e.cnt   = 3'(m_n[k]);
        e.empty = (m_n[k] == 0);
        e.fault = m_fault[k];
        return e;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]    = 32'h1000_0000;
            m_n[k]     = 0;
            m_fault[k] = 1'b0;
        end
    endtask

    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] seq;
            bit          bad;
            seq = m_pc[k] + modelInc(k);
            bad = redirect_target[0] || (k == 1 && redirect_target[1]);
            if (!stall) begin
                m_fault[k] = 1'b0;
                if (trap_enable) begin
                    m_pc[k] = trap_vector & 32'hFFFF_FFFC;
                    m_n[k]  = 0;
                end else if (redirect_enable) begin
                    if (bad) m_fault[k] = 1'b1;
                    else     m_pc[k] = redirect_target;
                end else if (ret && m_n[k] > 0) begin
                    m_pc[k] = m_stk[k][m_n[k]-1];
                    if (call) m_stk[k][m_n[k]-1] = seq;
                    else      m_n[k] = m_n[k] - 1;
                end else begin
                    if (call) begin
                        if (m_n[k] == 4) begin
                            for (int i = 0; i < 3; i++) m_stk[k][i] = m_stk[k][i+1];
                            m_stk[k][3] = seq;
                        end else begin
                            m_stk[k][m_n[k]] = seq;
                            m_n[k] = m_n[k] + 1;
                        end
                    end
                    m_pc[k] = seq;
                end
            end
        end
    endtask

    task automatic pushExpected();
        sb_c.push_back(makeExp(0));
        sb_n.push_back(makeExp(1));
    endtask

    task automatic applyStimulus(input bit st, input bit comp, input bit tr,
                                 input logic [31:0] tv, input bit rd,
                                 input logic [31:0] rt, input bit cl, input bit rt_);
        @(negedge clk);
        stall           = st;
        is_compressed   = comp;
        trap_enable     = tr;
        trap_vector     = tv;
        redirect_enable = rd;
        redirect_target = rt;
        call            = cl;
        ret             = rt_;
        modelStep();
        pushExpected();
    endtask

    // Reset is asserted between edges with whatever inputs are present
    task automatic resetDut();
        @(negedge clk);
        modelReset();
        pushExpected();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        stall = 1'b0; is_compressed = 1'b0; trap_enable = 1'b0; trap_vector = '0;
        redirect_enable = 1'b0; redirect_target = '0; call = 1'b0; ret = 1'b0;
        reset_n = 1'b1;
        modelStep();
        pushExpected();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t ec, en;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (sb_c.size() > 0 && sb_n.size() > 0) begin
                ec = sb_c.pop_front();
                en = sb_n.pop_front();
                checkOutput("c_pc_current", pc_c, ec.pc);
                checkOutput("c_pc_next", pcn_c, ec.pcn);
                checkOutput("c_ras_top", top_c, ec.top);
                checkOutput("c_ras_count", 32'(cnt_c), 32'(ec.cnt));
                checkOutput("c_ras_empty", 32'(empty_c), 32'(ec.empty));
                checkOutput("c_misaligned_fault", 32'(fault_c), 32'(ec.fault));
                checkOutput("nc_pc_current", pc_n, en.pc);
                checkOutput("nc_pc_next", pcn_n, en.pcn);
                checkOutput("nc_ras_top", top_n, en.top);
                checkOutput("nc_ras_count", 32'(cnt_n), 32'(en.cnt));
                checkOutput("nc_ras_empty", 32'(empty_n), 32'(en.empty));
                checkOutput("nc_misaligned_fault", 32'(fault_n), 32'(en.fault));
            end
        end
    end

    initial begin
        resetDut();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        resetDut();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h2000, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'(i * 32'h100), 0, 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        end
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 32'h8000_0003, 1, 32'h3000, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h3001, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h3002, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 32'h3006, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) applyStimulus(1, 1, 0, 0, 1, 32'h4000, 1, 1);
        resetDut();

        for (int n = 0; n < 400; n++) begin
            bit          st, comp, tr, rd, cl, rr;
            logic [31:0] tv, rt;
            st   = ($urandom_range(7) == 0);
            comp = $urandom_range(1) == 1;
            tr   = ($urandom_range(15) == 0);
            rd   = ($urandom_range(7) == 0);
            cl   = ($urandom_range(3) == 0);
            rr   = ($urandom_range(3) == 0);
            tv   = $urandom;
            rt   = {$urandom_range(32'hFFFF), 14'h0, 2'($urandom_range(3))};
            applyStimulus(st, comp, tr, tv, rd, rt, cl, rr);
        end

        for (int w = 0; w < 8 && sb_c.size() > 0; w++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb_c.size() + sb_n.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
